// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART state encoding and frame constants          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } tx_state_t;

    function automatic int frame_bits(input bit parity_en);
        return parity_en ? FRAME_BITS_8E1 : FRAME_BITS_8N1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_gen : bit-period counter, ticks in the last clock of each bit |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == C_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_bit_tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered read data            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_write_en,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_read_en,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_empty,
    output logic             o_full
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_write;
    logic             w_do_read;

    assign w_do_write = i_write_en && (r_count != C_DEPTH);
    assign w_do_read  = i_read_en && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wptr] <= i_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            o_data_out <= '0;
        end else begin
            if (w_do_write) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_read) begin
                r_rptr     <= r_rptr + AW'(1);
                o_data_out <= r_mem[r_rptr];
            end
            case ({w_do_write, w_do_read})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_uart_tx : drains a sync_fifo and sends 8N1 / 8E1 UART frames  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_enable,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_fifo_read_en,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done,
    output logic [15:0]          o_frame_count
);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [2:0]           r_bit_idx;
    logic                 r_tx;
    logic                 r_read_en;
    logic                 r_busy;
    logic [15:0]          r_frame_count;

    logic w_bit_tick;
    logic w_baud_clear;
    logic w_start_ok;

    // Bit-timed states wrap the counter on their own tick, so holding it
    // cleared outside them restarts timing on every state change.
    assign w_baud_clear = (r_state == S_IDLE) || (r_state == S_POP) || (r_state == S_LOAD);
    assign w_start_ok   = i_enable && !i_fifo_empty;

    baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_baud_clear),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_bit_idx     <= '0;
            r_tx          <= 1'b1;
            r_read_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_read_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= S_POP;
                        r_read_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift   <= i_fifo_data;
                    r_parity  <= ^i_fifo_data;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= S_START;
                end
                S_START: begin
                    if (w_bit_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_state <= PARITY_EN ? S_PARITY : S_STOP;
                            r_tx    <= PARITY_EN ? r_parity : 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_tick) begin
                        r_frame_count <= r_frame_count + 16'd1;
                        if (w_start_ok) begin
                            r_state   <= S_POP;
                            r_read_en <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_read_en = r_read_en;
    assign o_tx           = r_tx;
    assign o_busy         = r_busy;
    assign o_tx_done      = (r_state == S_STOP) && w_bit_tick;
    assign o_frame_count  = r_frame_count;

endmodule
`default_nettype wire
